// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the BCD-to-segment decode table.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Non-decimal nibbles show a dash so that bad upstream data is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to {g,f,e,d,c,b,a} active-low decoder.
// Reusable by any display block that drives a 7-segment bus.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: prescaler, digit scan, per-frame
// snapshot, guard interval, leading-zero blanking and registered outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] BCD,
  input  logic [NUM_DIGITS-1:0]   DP_EN,
  input  logic                    BLANK_LZ,
  input  logic                    DISP_EN,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           p_q, p_d;
  logic [IW-1:0]           i_q, i_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dp_en_q, dp_en_d;
  logic                    blz_q, blz_d;
  logic                    p_wrap, frame_end;

  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              digit;
  logic [6:0]              digit_seg;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  // Next-state: prescaler, scan index and frame-end snapshot.
  always_comb begin
    p_wrap    = (p_q == P_LAST);
    frame_end = p_wrap && (i_q == I_LAST);
    p_d       = p_wrap ? '0 : p_q + 1'b1;
    i_d       = i_q;
    if (p_wrap) begin
      i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
    end
    bcd_d   = frame_end ? BCD      : bcd_q;
    dp_en_d = frame_end ? DP_EN    : dp_en_q;
    blz_d   = frame_end ? BLANK_LZ : blz_q;
  end

  // A digit is blanked when it and every digit to its left are zero.
  always_comb begin
    blank    = '0;
    zero_run = blz_d;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (bcd_d[4*k +: 4] == 4'd0);
      blank[k] = zero_run;
    end
  end

  assign digit = bcd_d[{i_d, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (digit),
    .seg    (digit_seg)
  );

  // Outputs are computed from post-edge state so they carry no extra lag.
  always_comb begin
    lit   = DISP_EN && (p_d >= P_GUARD) && !blank[i_d];
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << i_d);
      seg_d = digit_seg;
      dp_d  = !dp_en_d[i_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q     <= '0;
      i_q     <= '0;
      bcd_q   <= '0;
      dp_en_q <= '0;
      blz_q   <= 1'b0;
      AN      <= '1;
      SEG     <= SEG_OFF;
      DP      <= 1'b1;
    end else begin
      p_q     <= p_d;
      i_q     <= i_d;
      bcd_q   <= bcd_d;
      dp_en_q <= dp_en_d;
      blz_q   <= blz_d;
      AN      <= an_d;
      SEG     <= seg_d;
      DP      <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a 4-digit, 4-cycle-slot setup.
// Expected {AN,SEG,DP} words are queued per frame and compared each cycle.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        disp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  localparam logic [11:0] OFF = 12'hFFF;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .GUARD_CYCLES (1)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .BCD      (bcd),
    .DP_EN    (dp_en),
    .BLANK_LZ (blank_lz),
    .DISP_EN  (disp_en),
    .AN       (an),
    .SEG      (seg),
    .DP       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one frame: 4 slots x 4 cycles, cycle 0 of each slot is the guard.
  // segs = {d3,d2,d1,d0}; lit/dpm give per-digit lighting and DP request.
  function automatic void push_frame(input logic [27:0] segs, input logic [3:0] lit,
                                     input logic [3:0] dpm);
    logic [3:0] an_v;
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < 4; p++) begin
        if (p == 0 || !lit[d]) begin
          exp_q.push_back(OFF);
        end else begin
          an_v = ~(4'b0001 << d);
          exp_q.push_back({an_v, segs[7*d +: 7], ~dpm[d]});
        end
      end
    end
  endfunction

  task automatic test_reset();
    logic [11:0] got, exp_v;
    rst = 1'b1; bcd = 16'h0000; dp_en = 4'b0000; blank_lz = 1'b0; disp_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = {an, seg, dp};
      n_cmp++;
      if (got !== OFF) begin
        n_err++; $display("FAIL reset_hold c=%0d got=%h exp=%h", c, got, OFF);
      end
    end
    rst = 1'b0;
    push_frame({S0, S0, S0, S0}, 4'hF, 4'h0);
    for (int e = 0; e < 16; e++) begin
      if (e != 0) @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL reset_first_frame e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
  endtask

  task automatic test_digits();
    logic [11:0] got, exp_v;
    bcd = 16'h1259;
    push_frame({S1, S2, S5, S9}, 4'hF, 4'h0);
    push_frame({S1, S2, S5, S9}, 4'hF, 4'h0);
    for (int e = 0; e < 32; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL digits_1259 e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [11:0] got, exp_v;
    blank_lz = 1'b1;
    bcd = 16'h0005;
    push_frame({S0, S0, S0, S5}, 4'b0001, 4'h0);
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL blank_0005 e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
    bcd = 16'h0000;
    push_frame({S0, S0, S0, S0}, 4'b0001, 4'h0);
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL blank_0000 e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [11:0] got, exp_v;
    blank_lz = 1'b0;
    bcd = 16'h0059;
    push_frame({S0, S0, S5, S9}, 4'hF, 4'h0);
    push_frame({S0, S0, S5, S9}, 4'hF, 4'h0);
    push_frame({S0, S1, S0, S0}, 4'hF, 4'h0);
    for (int e = 0; e < 48; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL no_tearing e=%0d got=%h exp=%h", e, got, exp_v);
      end
      // Switch inputs inside the digit-1 slot of the second frame.
      if (e == 21) bcd = 16'h0100;
    end
  endtask

  task automatic test_invalid_dp();
    logic [11:0] got, exp_v;
    bcd = 16'h00A3; dp_en = 4'b0010; blank_lz = 1'b0;
    push_frame({S0, S0, SD, S3}, 4'hF, 4'b0010);
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL invalid_dp e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
    // Invalid nibble stops blanking; the blanked top digit loses its DP.
    bcd = 16'h0A00; dp_en = 4'b1111; blank_lz = 1'b1;
    push_frame({S0, SD, S0, S0}, 4'b0111, 4'b1111);
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL invalid_blank e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
  endtask

  task automatic test_disp_en();
    logic [11:0] got, exp_v;
    bcd = 16'h1259; dp_en = 4'b0101; blank_lz = 1'b0; disp_en = 1'b0;
    push_frame({S1, S2, S5, S9}, 4'h0, 4'b0101);
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL disp_off e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
    disp_en = 1'b1; dp_en = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, exp_v;
    push_frame({S1, S2, S5, S9}, 4'hF, 4'h0);
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL pre_reset e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
    // Reset lands in the digit-2 slot; pending expectations are abandoned.
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {an, seg, dp};
    n_cmp++;
    if (got !== OFF) begin
      n_err++; $display("FAIL mid_reset got=%h exp=%h", got, OFF);
    end
    push_frame({S0, S0, S0, S0}, 4'hF, 4'h0);
    push_frame({S1, S2, S5, S9}, 4'hF, 4'h0);
    for (int e = 0; e < 32; e++) begin
      if (e != 0) @(negedge clk);
      got = {an, seg, dp};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL post_reset e=%0d got=%h exp=%h", e, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blank_lz();
    test_no_tearing();
    test_invalid_dp();
    test_disp_en();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
